// File: rtl/shared_ram_arbiter.sv
// Two-client round-robin arbiter in front of a single-clock simple dual-port RAM.
// Grants are combinational (0 cycles), read data 1 cycle after rd_gnt; a read that hits the granted write address stalls.

module shared_ram_sdp #(
  parameter int SIZE  = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [SIZE-1:0] wdata,
  input  logic            re,
  input  logic [AW-1:0]   raddr,
  output logic [SIZE-1:0] rdata
);
  logic [SIZE-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

module shared_ram_arbiter #(
  parameter  int SIZE  = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      wr_req,
  input  logic [AW-1:0]   wr_addr0,
  input  logic [AW-1:0]   wr_addr1,
  input  logic [SIZE-1:0] wr_data0,
  input  logic [SIZE-1:0] wr_data1,
  output logic [1:0]      wr_gnt,
  input  logic [1:0]      rd_req,
  input  logic [AW-1:0]   rd_addr0,
  input  logic [AW-1:0]   rd_addr1,
  output logic [1:0]      rd_gnt,
  output logic [1:0]      rd_valid,
  output logic [SIZE-1:0] rd_data
);
  // last_q holds the index of the most recently granted requester
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last_q);
    logic [1:0] g;
    g = 2'b00;
    case (req)
      2'b01:   g = 2'b01;
      2'b10:   g = 2'b10;
      2'b11:   g = last_q ? 2'b01 : 2'b10;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

  logic            wr_last_q, wr_last_d;
  logic            rd_last_q, rd_last_d;
  logic [1:0]      rd_valid_q;
  logic [1:0]      rd_cand;
  logic [AW-1:0]   wr_addr_sel;
  logic [SIZE-1:0] wr_data_sel;
  logic [AW-1:0]   rd_addr_sel;
  logic            collide;

  always_comb begin
    wr_gnt      = rst_n ? rr_pick(wr_req, wr_last_q) : 2'b00;
    wr_addr_sel = wr_gnt[1] ? wr_addr1 : wr_addr0;
    wr_data_sel = wr_gnt[1] ? wr_data1 : wr_data0;

    rd_cand     = rst_n ? rr_pick(rd_req, rd_last_q) : 2'b00;
    rd_addr_sel = rd_cand[1] ? rd_addr1 : rd_addr0;
    // Write wins an address clash; the read simply retries next cycle.
    collide     = (|wr_gnt) && (|rd_cand) && (rd_addr_sel == wr_addr_sel);
    rd_gnt      = collide ? 2'b00 : rd_cand;

    wr_last_d = wr_last_q;
    if (|wr_gnt) wr_last_d = wr_gnt[1];
    rd_last_d = rd_last_q;
    if (|rd_gnt) rd_last_d = rd_gnt[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_last_q  <= 1'b1;
      rd_last_q  <= 1'b1;
      rd_valid_q <= 2'b00;
    end else begin
      wr_last_q  <= wr_last_d;
      rd_last_q  <= rd_last_d;
      rd_valid_q <= rd_gnt;
    end
  end

  assign rd_valid = rd_valid_q;

  shared_ram_sdp #(.SIZE(SIZE), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (|wr_gnt),
    .waddr (wr_addr_sel),
    .wdata (wr_data_sel),
    .re    (|rd_gnt),
    .raddr (rd_addr_sel),
    .rdata (rd_data)
  );
endmodule

// File: tb/tb_shared_ram_arbiter.sv
// Directed and random stimulus against a behavioural model of the arbitration rules and RAM contents.
module tb_shared_ram_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] wr_req, rd_req;
  logic [2:0] wr_addr0, wr_addr1, rd_addr0, rd_addr1;
  logic [7:0] wr_data0, wr_data1;
  logic [1:0] wr_gnt, rd_gnt, rd_valid;
  logic [7:0] rd_data;

  int errors = 0;
  int checks = 0;

  // model state
  logic [7:0] m_mem [8];
  int         m_wl, m_rl;
  logic [1:0] m_rdv;
  logic [7:0] m_rdd;

  shared_ram_arbiter #(.SIZE(8), .DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_req(wr_req), .wr_addr0(wr_addr0), .wr_addr1(wr_addr1),
    .wr_data0(wr_data0), .wr_data1(wr_data1), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [1:0] req, input int last);
    if (req == 2'b11) return (last == 1) ? 0 : 1;
    if (req[0]) return 0;
    if (req[1]) return 1;
    return -1;
  endfunction

  function automatic logic [1:0] onehot(input int idx);
    if (idx == 0) return 2'b01;
    if (idx == 1) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_wl  = 1;
    m_rl  = 1;
    m_rdv = 2'b00;
  endtask

  // Called just after a negedge with inputs already driven; returns at the next negedge.
  task automatic cycle();
    int w, c;
    logic [2:0] wa, ra;
    #1;
    chk("rd_valid", {30'd0, rd_valid}, {30'd0, m_rdv});
    if (m_rdv != 2'b00) chk("rd_data", {24'd0, rd_data}, {24'd0, m_rdd});
    w  = pick(wr_req, m_wl);
    c  = pick(rd_req, m_rl);
    wa = (w == 1) ? wr_addr1 : wr_addr0;
    ra = (c == 1) ? rd_addr1 : rd_addr0;
    if (w >= 0 && c >= 0 && wa == ra) c = -1;
    chk("wr_gnt", {30'd0, wr_gnt}, {30'd0, onehot(w)});
    chk("rd_gnt", {30'd0, rd_gnt}, {30'd0, onehot(c)});
    @(posedge clk);
    m_rdv = onehot(c);
    if (c >= 0) begin
      m_rdd = m_mem[ra];
      m_rl  = c;
    end
    if (w >= 0) begin
      m_mem[wa] = (w == 1) ? wr_data1 : wr_data0;
      m_wl = w;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [1:0] rr_exp [4];
    rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;

    // reset with every request asserted
    rst_n = 1'b0;
    wr_req = 2'b11; rd_req = 2'b11;
    wr_addr0 = 3'd1; wr_addr1 = 3'd2; wr_data0 = 8'h11; wr_data1 = 8'h22;
    rd_addr0 = 3'd4; rd_addr1 = 3'd6;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_wr_gnt", {30'd0, wr_gnt}, 32'd0);
    chk("reset_rd_gnt", {30'd0, rd_gnt}, 32'd0);
    chk("reset_rd_valid", {30'd0, rd_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd_req = 2'b00;

    // round-robin writes: addr1=0x11 / addr2=0x22
    for (int i = 0; i < 4; i++) begin
      #1 chk("rr_wr_gnt", {30'd0, wr_gnt}, {30'd0, rr_exp[i]});
      cycle();
    end

    // preload remaining addresses with i*0x11
    wr_req = 2'b01;
    for (int i = 0; i < 8; i++) begin
      if (i != 1 && i != 2) begin
        wr_addr0 = 3'(i); wr_data0 = 8'(i * 8'h11);
        cycle();
      end
    end
    wr_req = 2'b00;

    // readback of round-robin words
    rd_req = 2'b01; rd_addr0 = 3'd1;
    cycle();
    rd_addr0 = 3'd2;
    #1 chk("rb1_data", {24'd0, rd_data}, 32'h11);
    cycle();
    rd_req = 2'b00;
    #1 chk("rb2_data", {24'd0, rd_data}, 32'h22);
    cycle();

    // single write then read by the other requester
    wr_req = 2'b01; wr_addr0 = 3'd3; wr_data0 = 8'h5A;
    #1 chk("sw_wr_gnt", {30'd0, wr_gnt}, 32'h1);
    cycle();
    wr_req = 2'b00; rd_req = 2'b10; rd_addr1 = 3'd3;
    #1 chk("sr_rd_gnt", {30'd0, rd_gnt}, 32'h2);
    cycle();
    rd_req = 2'b00;
    #1 chk("sr_valid", {30'd0, rd_valid}, 32'h2);
    chk("sr_data", {24'd0, rd_data}, 32'h5A);
    cycle();

    // collision: write addr5 while reading addr5
    wr_req = 2'b01; wr_addr0 = 3'd5; wr_data0 = 8'hA5;
    rd_req = 2'b10; rd_addr1 = 3'd5;
    #1 chk("col_rd_gnt", {30'd0, rd_gnt}, 32'h0);
    chk("col_wr_gnt", {30'd0, wr_gnt}, 32'h1);
    cycle();
    wr_req = 2'b00;
    #1 chk("col_retry_gnt", {30'd0, rd_gnt}, 32'h2);
    cycle();
    rd_req = 2'b00;
    #1 chk("col_data", {24'd0, rd_data}, 32'hA5);
    cycle();

    // concurrent write and read on different addresses
    wr_req = 2'b01; wr_addr0 = 3'd0; wr_data0 = 8'h3C;
    rd_req = 2'b10; rd_addr1 = 3'd7;
    #1 chk("cc_wr_gnt", {30'd0, wr_gnt}, 32'h1);
    chk("cc_rd_gnt", {30'd0, rd_gnt}, 32'h2);
    cycle();
    wr_req = 2'b00; rd_req = 2'b00;
    #1 chk("cc_valid", {30'd0, rd_valid}, 32'h2);
    chk("cc_data", {24'd0, rd_data}, 32'h77);
    cycle();

    // random traffic
    for (int i = 0; i < 300; i++) begin
      wr_req   = 2'($urandom_range(0, 3));
      rd_req   = 2'($urandom_range(0, 3));
      wr_addr0 = 3'($urandom_range(0, 7));
      wr_addr1 = 3'($urandom_range(0, 7));
      rd_addr0 = 3'($urandom_range(0, 7));
      rd_addr1 = 3'($urandom_range(0, 7));
      wr_data0 = 8'($urandom_range(0, 255));
      wr_data1 = 8'($urandom_range(0, 255));
      cycle();
    end

    // async reset between edges during contended reads
    wr_req = 2'b00; rd_req = 2'b11; rd_addr0 = 3'd2; rd_addr1 = 3'd4;
    cycle();
    #2 rst_n = 1'b0;
    #1 chk("ar_wr_gnt", {30'd0, wr_gnt}, 32'h0);
    chk("ar_rd_gnt", {30'd0, rd_gnt}, 32'h0);
    chk("ar_rd_valid", {30'd0, rd_valid}, 32'h0);
    @(posedge clk);
    #1 chk("ar_hold_valid", {30'd0, rd_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    wr_req = 2'b11; wr_addr0 = 3'd6; wr_addr1 = 3'd0; wr_data0 = 8'h66; wr_data1 = 8'h00;
    #1 chk("ar_first_wr", {30'd0, wr_gnt}, 32'h1);
    chk("ar_first_rd", {30'd0, rd_gnt}, 32'h1);
    cycle();
    cycle();
    wr_req = 2'b00; rd_req = 2'b00;
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/shared_ram_arbiter.md
# shared_ram_arbiter

Two-requester arbiter that shares one single-clock simple dual-port RAM (one write port, one read port, registered read) between two clients. It instantiates the RAM with both port clocks tied to `clk`. Write and read ports are arbitrated independently with round-robin fairness. Same-cycle read/write address collisions are prevented by stalling the read. It sits between two bus-side clients (e.g. a producer engine and a host-access path) and the shared storage.

## Interface
- `SIZE`, default 8, word width in bits
- `DEPTH`, default 8, number of words; `AW = $clog2(DEPTH)`
- `clk`  in  1  single clock for arbiter and RAM (both RAM ports)
- `rst_n`  in  1  asynchronous, active-low reset
- `wr_req[1:0]`  in  2  write request per requester; held until granted
- `wr_addr0`, `wr_addr1`  in  AW  write address per requester
- `wr_data0`, `wr_data1`  in  SIZE  write data per requester
- `wr_gnt[1:0]`  out  2  write grant; combinational; one-hot or zero
- `rd_req[1:0]`  in  2  read request per requester; held until granted
- `rd_addr0`, `rd_addr1`  in  AW  read address per requester
- `rd_gnt[1:0]`  out  2  read grant; combinational; one-hot or zero
- `rd_valid[1:0]`  out  2  registered; bit i high = `rd_data` belongs to requester i
- `rd_data`  out  SIZE  RAM read output, shared by both requesters

## Operation
- Write arbiter: candidate set = `wr_req`. One bit set -> grant it. Both set -> grant the requester not granted last (`wr_last`). `wr_gnt[i]` high -> RAM write enable, address/data muxed from requester i, write committed at the next `clk` edge.
- `wr_last` updates to i only on a cycle with `wr_gnt[i]`. Reset value 1, so requester 0 wins the first contention.
- Read arbiter: same rule with its own pointer `rd_last` (reset 1). Produces candidate read grant c.
- Collision rule: if `wr_gnt` is nonzero and candidate read address == granted write address, `rd_gnt` = 0 that cycle and `rd_last` does not update. Write always wins. Read retries next cycle. No forwarding.
- Otherwise `rd_gnt[c]` = 1 and the RAM read address = `rd_addr` of c.
- `rd_valid <= rd_gnt` each cycle (registered). `rd_data` is the RAM's registered output. Both are valid in the same cycle.
- Requester contract: hold req/addr/data stable until grant seen. Deassert or change in the cycle after grant. Arbiter does not check this.
- Write and read ports are independent: one write and one read may both be granted in the same cycle (different addresses), to same or different requesters.

## Timing
- Grant latency: 0 cycles (combinational from req, pointers, addresses).
- Write: data readable by a read granted in the cycle after `wr_gnt`.
- Read: `rd_valid`/`rd_data` 1 cycle after `rd_gnt`. Throughput 1 read + 1 write per cycle.
- Fairness: under continuous contention each requester is granted every 2nd cycle per port. Worst-case wait 1 cycle; 2 if hit by a collision stall; unbounded only if a writer targets the same address every cycle.
- Reset (`rst_n` low, asynchronous): `wr_gnt`=0, `rd_gnt`=0 (gated by `rst_n`), `rd_valid`=0, `wr_last`=`rd_last`=1. RAM contents unchanged. `rd_data` not reset; undefined while `rd_valid`=0.
- Reset mid-operation: a read granted in the reset cycle produces no `rd_valid`. A write in flight at reset assertion is not guaranteed.
- Address wrap: none. Addresses ≥ DEPTH (non-power-of-2 DEPTH) are a caller error.

## Test plan
- Reset: `rst_n`=0 with all reqs high -> all grants 0, `rd_valid`=0. Release -> first contended write grant `wr_gnt`=2'b01.
- Single write/read: req0 writes 0x5A to addr 3 (`wr_gnt`=01 in same cycle). Next cycle req1 reads addr 3 -> `rd_gnt`=10, then `rd_valid`=10 with `rd_data`=0x5A one cycle later.
- Round-robin: both write continuously to addrs 1/2 with data 0x11/0x22 for 4 cycles -> `wr_gnt` sequence 01,10,01,10. Readback of addr 1 = 0x11, addr 2 = 0x22.
- Collision: in the same cycle req0 writes addr 5 = 0xA5 and req1 reads addr 5 -> `rd_gnt`=00, `rd_last` unchanged. Next cycle `rd_gnt`=10, then `rd_data`=0xA5.
- Concurrent ports: req0 writes addr 0 while req1 reads addr 7 (preloaded 0x77) -> `wr_gnt`=01 and `rd_gnt`=10 in the same cycle. Next cycle `rd_valid`=10, `rd_data`=0x77.
- Async reset mid-stream: drop `rst_n` between clock edges during contended reads -> grants and `rd_valid` go 0 immediately. After release, requester 0 wins first.
